fetch_cur_rotbuf: RTL
=====================

Name: fetch_cur_rotbuf

Overview:
Parametrised N-stage rotating current-LCU pixel buffer for the fetch stage. It has NUM_RD+1 internal banks. One bank is always the external-load (write) bank. Each of NUM_RD pipeline consumers (stage 0 = mc, stage 1 = db, further stages optional) reads its own bank. On every sys start, bank roles rotate by one. Unlike the fixed 3-bank rotator, this block adds:
- per-bank load-complete tracking
- read-valid signalling
- underrun/overflow error pulses
- registered 1-cycle read latency

Parameters:
NUM_RD, 2, number of read stages; internal bank count NUM_BANK = NUM_RD+1 (localparam); legal range 1..7
DATA_W, 256, word width (32*`PIXEL_WIDTH)
ADDR_W, 6, word address width; bank depth = 2**ADDR_W
PTR_W, 3, width of bank pointer; must satisfy 2**PTR_W >= NUM_BANK

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sysif_start_i  in  1  LCU start pulse; rotates banks
ext_load_valid_i  in  1  write enable
ext_load_addr_i  in  ADDR_W  write word address
ext_load_data_i  in  DATA_W  write data
ext_load_done_i  in  1  current write bank fully loaded
load_ready_o  out  1  write bank not yet marked done
rd_en_i  in  NUM_RD  per-stage read enable, bit k = stage k
rd_addr_i  in  NUM_RD*ADDR_W  per-stage read address, slice k
rd_data_o  out  NUM_RD*DATA_W  per-stage read data, slice k
rd_vld_o  out  NUM_RD  per-stage read data valid
underrun_o  out  1  1-cycle pulse: rotation with write bank not done
overflow_o  out  1  1-cycle pulse: write dropped
wr_bank_o  out  PTR_W  current write bank index (debug)

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: wr_ptr=0, bank_done[all]=0, rd_data_o=0, rd_vld_o=0, underrun_o=0, overflow_o=0. load_ready_o=1 after reset (combinational = ~bank_done[wr_ptr]).
- Reset asserted mid-operation discards all done flags and any pending read. Bank storage contents are not cleared.
- Bank mapping:
  - write bank = wr_ptr
  - stage k bank = (wr_ptr + NUM_BANK - 1 - k) mod NUM_BANK
  - The mapping is combinational from the registered wr_ptr.
- Rotation: when sysif_start_i=1 at a clock edge:
  - wr_ptr <= (wr_ptr==NUM_BANK-1) ? 0 : wr_ptr+1
  - Old write bank becomes stage 0. Old stage NUM_RD-1 bank becomes the new write bank and its bank_done is cleared.
  - If bank_done[old wr_ptr]=0 and ext_load_done_i=0 in that cycle, underrun_o pulses the next cycle. Rotation still occurs and stage 0 holds a not-done bank.
- Write:
  - If ext_load_valid_i=1 and bank_done[wr_ptr]=0, the word is written to bank wr_ptr at ext_load_addr_i.
  - If bank_done[wr_ptr]=1, the write is dropped and overflow_o pulses the next cycle.
- Done: ext_load_done_i=1 sets bank_done[wr_ptr].
- Simultaneous events in one cycle: write, done and start all apply to the pre-rotation wr_ptr.
  - write+done in the same cycle: write accepted.
  - done+start: old bank enters stage 0 with done=1, no underrun.
- Read:
  - rd_en_i[k]=1 at edge T: rd_data_o slice k = bank[stage k bank at T][rd_addr k] at T+1, and rd_vld_o[k]=bank_done of that bank at T.
  - If the bank is not done, data slice is forced to 0 and rd_vld_o[k]=0.
  - rd_en_i[k]=0: rd_vld_o[k]=0 next cycle; rd_data slice holds its last value.
  - A read in the same cycle as start uses the pre-rotation mapping.
- Read/write bank collision is impossible by construction. No bank is ever both write bank and a stage bank.
- Storage: NUM_BANK arrays of 2**ADDR_W x DATA_W, synchronous read, one write port shared across banks via wr_ptr.
- Address wrap: addresses are ADDR_W bits; no bounds checking.
- NUM_RD=1 degenerates to ping-pong (2 banks).

Test Plan:
Defaults: NUM_RD=2, ADDR_W=6, DATA_W=256.
1. Reset -> wr_bank_o=0, load_ready_o=1, rd_vld_o=2'b00, all outputs 0; reset asserted mid-load clears done flags.
2. Load bank0 addr 0..63 with data=addr, done, start; then start again with bank1 loaded -> stage1 rd_en addr 5 returns 5 one cycle later with rd_vld_o[1]=1; stage0 returns bank1 data.
3. Start with no done -> underrun_o=1 for exactly one cycle; stage0 reads return 0 with rd_vld_o[0]=0; wr_bank_o advances 0->1.
4. done then write to addr 3 -> overflow_o pulses; subsequent read of addr 3 after rotation returns original data.
5. Same cycle write addr 7 + done + start + stage0 read -> write lands in old bank (visible next LCU on stage0, rd_vld=1); read uses pre-rotation bank; no underrun.
6. 7 consecutive starts -> wr_bank_o sequence 1,2,0,1,2,0,1; new write bank's done cleared each time (load_ready_o=1).

Source files
------------

// File: rtl/fetch_cur_rotbuf.sv
// rtl/fetch_cur_rotbuf.sv - rotating current-LCU pixel buffer, NUM_RD readers plus one load bank
// Bank roles rotate on every sys start; per-bank done flags gate read-valid and write acceptance.
module fetch_cur_rotbuf #(
   parameter int NUM_RD = 2,
   parameter int DATA_W = 256,
   parameter int ADDR_W = 6,
   parameter int PTR_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sysif_start_i,
   input  logic                     ext_load_valid_i,
   input  logic [ADDR_W-1:0]        ext_load_addr_i,
   input  logic [DATA_W-1:0]        ext_load_data_i,
   input  logic                     ext_load_done_i,
   output logic                     load_ready_o,
   input  logic [NUM_RD-1:0]        rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_vld_o,
   output logic                     underrun_o,
   output logic                     overflow_o,
   output logic [PTR_W-1:0]         wr_bank_o
);

   localparam int NUM_BANK = NUM_RD + 1;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int NPAD     = 1 << PTR_W;

   logic [DATA_W-1:0]        mem_q [NUM_BANK][DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   // Padded to the full pointer range so the pointer can index it directly.
   logic [NPAD-1:0]          bank_done_q, bank_done_d;
   logic [NUM_RD*DATA_W-1:0] rd_data_q;
   logic [NUM_RD-1:0]        rd_vld_q;
   logic                     underrun_q, overflow_q;
   logic [PTR_W-1:0]         stage_bank [NUM_RD];
   logic [DATA_W-1:0]        rd_word [NUM_RD];
   logic                     cur_done;
   logic                     wr_acc;

   assign cur_done     = bank_done_q[wr_ptr_q];
   assign wr_acc       = ext_load_valid_i && !cur_done;
   assign load_ready_o = ~cur_done;
   assign rd_data_o    = rd_data_q;
   assign rd_vld_o     = rd_vld_q;
   assign underrun_o   = underrun_q;
   assign overflow_o   = overflow_q;
   assign wr_bank_o    = wr_ptr_q;

   // Stage 0 sits one bank behind the write bank, stage k sits k+1 behind.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         stage_bank[k] = PTR_W'((int'(wr_ptr_q) + NUM_BANK - 1 - k) % NUM_BANK);
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd_word[k] = '0;
         for (int b = 0; b < NUM_BANK; b++) begin
            if (stage_bank[k] == PTR_W'(b) && bank_done_q[stage_bank[k]]) begin
               rd_word[k] = mem_q[b][rd_addr_i[k*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      bank_done_d = bank_done_q;
      if (ext_load_done_i) begin
         bank_done_d[wr_ptr_q] = 1'b1;
      end
      if (sysif_start_i) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_BANK - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         bank_done_d[wr_ptr_d] = 1'b0;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < NUM_BANK; b++) begin
            if (wr_ptr_q == PTR_W'(b)) begin
               mem_q[b][ext_load_addr_i] <= ext_load_data_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         bank_done_q <= '0;
         rd_data_q   <= '0;
         rd_vld_q    <= '0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         bank_done_q <= bank_done_d;
         underrun_q  <= sysif_start_i && !cur_done && !ext_load_done_i;
         overflow_q  <= ext_load_valid_i && cur_done;
         for (int k = 0; k < NUM_RD; k++) begin
            rd_vld_q[k] <= rd_en_i[k] && bank_done_q[stage_bank[k]];
            if (rd_en_i[k]) begin
               rd_data_q[k*DATA_W +: DATA_W] <= rd_word[k];
            end
         end
      end
   end

endmodule
